// File: rtl/vec_reduce_engine_if.sv
// vec_reduce_engine_if: control handshake, s2 memory port and result bus of the reduce engine.
// Revision 1.0
`default_nettype none

interface vec_reduce_engine_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 14,
  parameter int COUNT_WIDTH = 11
);
  logic                   start;
  logic [COUNT_WIDTH-1:0] cfg_count;
  logic                   busy;
  logic                   done;
  logic [ADDR_WIDTH-1:0]  mem_address;
  logic                   mem_write;
  logic [DATA_WIDTH-1:0]  mem_writedata;
  logic [DATA_WIDTH-1:0]  mem_readdata;
  logic [63:0]            result_sum;
  logic [DATA_WIDTH-1:0]  result_min;
  logic [DATA_WIDTH-1:0]  result_max;

  modport master (
    output start, cfg_count, mem_readdata,
    input  busy, done, mem_address, mem_write, mem_writedata,
    input  result_sum, result_min, result_max
  );

  modport slave (
    input  start, cfg_count, mem_readdata,
    output busy, done, mem_address, mem_write, mem_writedata,
    output result_sum, result_min, result_max
  );
endinterface

`default_nettype wire

// File: rtl/vec_reduce_engine.sv
// vec_reduce_engine: streams product words from a source bank, reduces to sum/min/max and
// writes the four result words to a destination bank. Revision 1.0
`default_nettype none

module vec_reduce_engine #(
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 10,
  parameter int ADDR_WIDTH   = 14,
  parameter int SRC_BANK     = 2,
  parameter int DST_BANK     = 3,
  parameter int READ_LATENCY = 2
) (
  input  wire logic          fpga_clk1_50,
  input  wire logic          hps_fpga_reset_n,
  vec_reduce_engine_if.slave bus
);

  localparam int CW        = INDEX_WIDTH + 1;
  localparam int BANK_BITS = ADDR_WIDTH - INDEX_WIDTH;
  localparam int ACC_W     = 64;
  localparam logic [CW-1:0]        MAX_COUNT = CW'(1 << INDEX_WIDTH);
  localparam logic [BANK_BITS-1:0] SRC_SEL   = BANK_BITS'(SRC_BANK);
  localparam logic [BANK_BITS-1:0] DST_SEL   = BANK_BITS'(DST_BANK);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d, idx_q, idx_d;
  logic [1:0]               wsel_q, wsel_d;
  logic [READ_LATENCY-1:0]  pipe_q, pipe_d, pipe_shift;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [DATA_WIDTH-1:0]    min_q, min_d, max_q, max_d;
  logic                     busy_q, busy_d, done_q, done_d, mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0]    mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0]    mem_writedata_q, mem_writedata_d;
  logic [ACC_W-1:0]         res_sum_q, res_sum_d;
  logic [DATA_WIDTH-1:0]    res_min_q, res_min_d, res_max_q, res_max_d;
  logic                     issue, enter_write;
  logic [CW-1:0]            cfg_clamped;
  logic [DATA_WIDTH-1:0]    rd;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    wsel_d          = wsel_q;
    acc_d           = acc_q;
    min_d           = min_q;
    max_d           = max_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    res_sum_d       = res_sum_q;
    res_min_d       = res_min_q;
    res_max_d       = res_max_q;
    issue           = 1'b0;
    enter_write     = 1'b0;
    rd              = bus.mem_readdata;
    pipe_shift      = pipe_q << 1;
    cfg_clamped     = (bus.cfg_count > MAX_COUNT) ? MAX_COUNT : bus.cfg_count;

    // The pipe tail marks the cycle in which the word issued READ_LATENCY cycles ago is valid.
    if (pipe_q[READ_LATENCY-1]) begin
      acc_d = acc_q + ACC_W'(rd);
      min_d = (rd < min_q) ? rd : min_q;
      max_d = (rd > max_q) ? rd : max_q;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cnt_d         = cfg_clamped;
          idx_d         = '0;
          acc_d         = '0;
          min_d         = '1;
          max_d         = '0;
          busy_d        = 1'b1;
          mem_address_d = {SRC_SEL, {INDEX_WIDTH{1'b0}}};
          if (cfg_clamped == '0) enter_write = 1'b1;
          else                   state_d     = S_READ;
        end
      end
      S_READ: begin
        issue = 1'b1;
        if (idx_q + 1'b1 == cnt_q) begin
          state_d = S_DRAIN;
        end else begin
          idx_d         = idx_q + 1'b1;
          mem_address_d = {SRC_SEL, idx_d[INDEX_WIDTH-1:0]};
        end
      end
      S_DRAIN: begin
        if (pipe_shift == '0) enter_write = 1'b1;
      end
      S_WRITE: begin
        if (wsel_q == 2'd3) begin
          state_d     = S_DONE;
          mem_write_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else begin
          wsel_d        = wsel_q + 2'd1;
          mem_address_d = {DST_SEL, INDEX_WIDTH'(wsel_d)};
          case (wsel_d)
            2'd1:    mem_writedata_d = acc_q[2*DATA_WIDTH-1:DATA_WIDTH];
            2'd2:    mem_writedata_d = min_q;
            default: mem_writedata_d = max_q;
          endcase
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Results load from the post-capture values so they are valid in the first write cycle.
    if (enter_write) begin
      state_d         = S_WRITE;
      wsel_d          = 2'd0;
      mem_write_d     = 1'b1;
      mem_address_d   = {DST_SEL, {INDEX_WIDTH{1'b0}}};
      mem_writedata_d = acc_d[DATA_WIDTH-1:0];
      res_sum_d       = acc_d;
      res_min_d       = min_d;
      res_max_d       = max_d;
    end

    pipe_d = pipe_shift | READ_LATENCY'(issue);
  end

  always_ff @(posedge fpga_clk1_50) begin
    if (!hps_fpga_reset_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      wsel_q          <= '0;
      pipe_q          <= '0;
      acc_q           <= '0;
      min_q           <= '1;
      max_q           <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      res_sum_q       <= '0;
      res_min_q       <= '0;
      res_max_q       <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      wsel_q          <= wsel_d;
      pipe_q          <= pipe_d;
      acc_q           <= acc_d;
      min_q           <= min_d;
      max_q           <= max_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      res_sum_q       <= res_sum_d;
      res_min_q       <= res_min_d;
      res_max_q       <= res_max_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_writedata = mem_writedata_q;
  assign bus.result_sum    = res_sum_q;
  assign bus.result_min    = res_min_q;
  assign bus.result_max    = res_max_q;

endmodule

`default_nettype wire

// File: tb/tb_vec_reduce_engine.sv
// tb_vec_reduce_engine: directed tests of vec_reduce_engine against a latency-2 memory model.
// Revision 1.0
`default_nettype none

module tb_vec_reduce_engine;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vec_reduce_engine_if bif ();

  vec_reduce_engine #(.READ_LATENCY(RL)) dut (
    .fpga_clk1_50     (clk),
    .hps_fpga_reset_n (rst_n),
    .bus              (bif)
  );

  logic [31:0] src     [0:1023];
  logic [31:0] dst     [0:3];
  logic [31:0] rd_pipe [0:RL-1];
  int n_writes = 0;
  int n_dones  = 0;
  int n_bad    = 0;
  int tests    = 0;
  int fails    = 0;

  always @(posedge clk) begin
    rd_pipe[0] <= (bif.mem_address[13:10] == 4'd2) ? src[bif.mem_address[9:0]] : 32'hDEAD_BEEF;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (bif.mem_write && bif.mem_address[13:10] == 4'd3 && bif.mem_address[9:2] == 8'd0)
      dst[bif.mem_address[1:0]] <= bif.mem_writedata;
  end
  assign bif.mem_readdata = rd_pipe[RL-1];

  always @(negedge clk) begin
    if (bif.mem_write) n_writes <= n_writes + 1;
    if (bif.done) n_dones <= n_dones + 1;
    if (bif.busy && !bif.mem_write && bif.mem_address[13:10] != 4'd2) n_bad <= n_bad + 1;
  end

  // done_at counts cycles after the accept edge: 1 is the first cycle with busy expected high.
  task automatic run(input int n, output int done_at, output logic busy1);
    @(negedge clk); bif.start = 1'b1; bif.cfg_count = 11'(n);
    @(negedge clk); bif.start = 1'b0; busy1 = bif.busy; done_at = 1;
    while (bif.done !== 1'b1 && done_at < 3000) begin
      @(negedge clk); done_at++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bif.start = 1'b1; bif.cfg_count = 11'd4;
    repeat (3) @(negedge clk);
    tests++; if (bif.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bif.busy); end
    tests++; if (bif.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bif.done); end
    tests++; if (bif.mem_write !== 1'b0) begin fails++; $display("FAIL reset_write got %b want 0", bif.mem_write); end
    tests++; if (bif.mem_address !== 14'd0) begin fails++; $display("FAIL reset_addr got %h want 0", bif.mem_address); end
    tests++; if (bif.result_sum !== 64'd0) begin fails++; $display("FAIL reset_sum got %h want 0", bif.result_sum); end
    tests++; if (bif.result_min !== 32'd0 || bif.result_max !== 32'd0) begin
      fails++; $display("FAIL reset_minmax got %h/%h want 0/0", bif.result_min, bif.result_max); end
    bif.start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int d; logic b; int w0;
    src[0] = 32'd5; src[1] = 32'd1; src[2] = 32'd9; src[3] = 32'd3;
    #1 w0 = n_writes;
    run(4, d, b);
    tests++; if (b !== 1'b1) begin fails++; $display("FAIL basic_busy got %b want 1", b); end
    tests++; if (d != 11) begin fails++; $display("FAIL basic_done_time got %0d want 11", d); end
    tests++; if (dst[0] !== 32'd18 || dst[1] !== 32'd0) begin
      fails++; $display("FAIL basic_sum_words got %h/%h want 00000012/00000000", dst[0], dst[1]); end
    tests++; if (dst[2] !== 32'd1 || dst[3] !== 32'd9) begin
      fails++; $display("FAIL basic_minmax_words got %h/%h want 1/9", dst[2], dst[3]); end
    tests++; if (bif.result_sum !== 64'd18 || bif.result_min !== 32'd1 || bif.result_max !== 32'd9) begin
      fails++; $display("FAIL basic_results got %h/%h/%h want 18/1/9", bif.result_sum, bif.result_min, bif.result_max); end
    tests++; if (n_writes - w0 != 4) begin fails++; $display("FAIL basic_write_count got %0d want 4", n_writes - w0); end
    @(negedge clk);
    tests++; if (bif.busy !== 1'b0 || bif.done !== 1'b0) begin
      fails++; $display("FAIL basic_idle got busy=%b done=%b want 0/0", bif.busy, bif.done); end
  endtask

  task automatic test_empty;
    int d; logic b;
    run(0, d, b);
    tests++; if (d != 5) begin fails++; $display("FAIL empty_done_time got %0d want 5", d); end
    tests++; if (dst[0] !== 32'd0 || dst[1] !== 32'd0 || dst[2] !== 32'hFFFF_FFFF || dst[3] !== 32'd0) begin
      fails++; $display("FAIL empty_words got %h %h %h %h want 0 0 ffffffff 0", dst[0], dst[1], dst[2], dst[3]); end
    tests++; if (bif.result_min !== 32'hFFFF_FFFF || bif.result_sum !== 64'd0) begin
      fails++; $display("FAIL empty_results got %h/%h want 0/ffffffff", bif.result_sum, bif.result_min); end
  endtask

  task automatic test_ignore_start;
    int k; int w0; int d0;
    src[0] = 32'd2; src[1] = 32'd8; src[2] = 32'd4;
    #1 w0 = n_writes; d0 = n_dones;
    @(negedge clk); bif.start = 1'b1; bif.cfg_count = 11'd3;
    @(negedge clk); bif.start = 1'b0; k = 1;
    while (bif.done !== 1'b1 && k < 100) begin
      @(negedge clk); k++;
      bif.start = (k == 3 || k == 6); bif.cfg_count = 11'd5;
    end
    bif.start = 1'b1; bif.cfg_count = 11'd5;
    @(negedge clk); bif.start = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    tests++; if (k != 10) begin fails++; $display("FAIL ignore_done_time got %0d want 10", k); end
    tests++; if (n_dones - d0 != 1) begin fails++; $display("FAIL ignore_done_count got %0d want 1", n_dones - d0); end
    tests++; if (n_writes - w0 != 4) begin fails++; $display("FAIL ignore_write_count got %0d want 4", n_writes - w0); end
    tests++; if (bif.busy !== 1'b0) begin fails++; $display("FAIL ignore_idle got %b want 0", bif.busy); end
    tests++; if (bif.result_sum !== 64'd14 || bif.result_min !== 32'd2 || bif.result_max !== 32'd8) begin
      fails++; $display("FAIL ignore_results got %h/%h/%h want 14/2/8", bif.result_sum, bif.result_min, bif.result_max); end
  endtask

  task automatic test_full(input int cfg, input string tag);
    int d; logic b; int bad0;
    for (int i = 0; i < 1024; i++) src[i] = 32'hFFFF_FFFF;
    #1 bad0 = n_bad;
    run(cfg, d, b);
    tests++; if (d != 1031) begin fails++; $display("FAIL %s_done_time got %0d want 1031", tag, d); end
    tests++; if (bif.result_sum !== 64'h0000_03FF_FFFF_FC00) begin
      fails++; $display("FAIL %s_sum got %h want 000003fffffffc00", tag, bif.result_sum); end
    tests++; if (dst[0] !== 32'hFFFF_FC00 || dst[1] !== 32'h0000_03FF) begin
      fails++; $display("FAIL %s_sum_words got %h/%h want fffffc00/000003ff", tag, dst[0], dst[1]); end
    tests++; if (dst[2] !== 32'hFFFF_FFFF || dst[3] !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL %s_minmax_words got %h/%h want ffffffff/ffffffff", tag, dst[2], dst[3]); end
    tests++; if (n_bad - bad0 != 0) begin fails++; $display("FAIL %s_bank_bounds got %0d stray reads want 0", tag, n_bad - bad0); end
  endtask

  task automatic test_reset_abort;
    int d; logic b; int w0; int d0;
    for (int i = 0; i < 1024; i++) src[i] = 32'd1;
    @(negedge clk); bif.start = 1'b1; bif.cfg_count = 11'd200;
    @(negedge clk); bif.start = 1'b0;
    repeat (100) @(negedge clk);
    tests++; if (bif.mem_address !== 14'd2148) begin
      fails++; $display("FAIL abort_addr got %h want %h", bif.mem_address, 14'd2148); end
    #1 w0 = n_writes; d0 = n_dones;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    tests++; if (n_writes - w0 != 0 || n_dones - d0 != 0) begin
      fails++; $display("FAIL abort_quiet got writes=%0d dones=%0d want 0/0", n_writes - w0, n_dones - d0); end
    tests++; if (bif.busy !== 1'b0 || bif.result_sum !== 64'd0) begin
      fails++; $display("FAIL abort_state got busy=%b sum=%h want 0/0", bif.busy, bif.result_sum); end
    src[0] = 32'd7; src[1] = 32'd7;
    run(2, d, b);
    tests++; if (d != 9) begin fails++; $display("FAIL abort_rerun_time got %0d want 9", d); end
    tests++; if (bif.result_sum !== 64'd14 || dst[0] !== 32'd14 || dst[2] !== 32'd7 || dst[3] !== 32'd7) begin
      fails++; $display("FAIL abort_rerun got sum=%h w0=%h min=%h max=%h want 14/14/7/7", bif.result_sum, dst[0], dst[2], dst[3]); end
  endtask

  initial begin
    bif.start = 1'b0;
    bif.cfg_count = 11'd0;
    for (int i = 0; i < 1024; i++) src[i] = 32'd0;
    test_reset;
    test_basic;
    test_empty;
    test_ignore_start;
    test_full(1024, "full");
    test_full(2047, "clamp");
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
